lzc_seq_scanner: RTL and testbench

- Multi-cycle leading-zero counter for operands wider than one LZC core.
- Scans the operand MSB-first, one CHUNK-wide slice per cycle, through a single instance of the team's combinational LZC core configured with WIDTH=CHUNK.
- Stops at the first non-zero slice.
- Sits between an operand producer (valid/ready) and a normalisation/result consumer (valid/ready), trading latency for area.

---
 rtl/lzc_seq_scanner.sv | 168 ++++++++++++++++
 tb/tb_lzc_seq_scanner.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lzc_seq_scanner.sv
// rtl/lzc_seq_scanner.sv - multi-cycle leading-zero counter scanning CHUNK-wide slices MSB-first
//
// lzc_core: combinational leading-zero counter for one WIDTH-bit slice.
//   data  in  WIDTH           slice, bit WIDTH-1 is the MSB
//   count out $clog2(WIDTH)   leading zeros (meaningful only when valid=1)
//   valid out 1               slice has at least one set bit
//
// lzc_seq_scanner: scans a DATA_W operand one slice per cycle, stopping at the
// first non-zero slice.
//   clk       in  1        clock, all state on rising edge
//   rst_n     in  1        synchronous active-low reset
//   in_valid  in  1        operand valid
//   in_ready  out 1        block idle and able to accept an operand
//   in_data   in  DATA_W   operand, bit DATA_W-1 is the MSB
//   out_valid out 1        result valid
//   out_ready in  1        consumer accepts result
//   out_count out CNT_W    leading zeros, 0..DATA_W
//   out_zero  out 1        operand was all zeros
//   out_norm  out DATA_W   operand << out_count (only with LZC_SEQ_NORM_EN)
//
// Optional build macro: LZC_SEQ_NORM_EN adds the out_norm port and its shifter.

module lzc_core #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]         data,
    output logic [$clog2(WIDTH)-1:0] count,
    output logic                     valid
);
    localparam int CW = $clog2(WIDTH);

    // Priority search from the MSB; the first set bit found wins.
    always_comb begin
        count = '0;
        valid = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!valid && data[i]) begin
                count = CW'(WIDTH - 1 - i);
                valid = 1'b1;
            end
        end
    end
endmodule

module lzc_seq_scanner #(
    parameter  int CHUNK  = 16,
    parameter  int CHUNKS = 4,
    localparam int DATA_W = CHUNK * CHUNKS,
    localparam int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_zero
`ifdef LZC_SEQ_NORM_EN
    ,
    output logic [DATA_W-1:0] out_norm
`endif
);
    localparam int CORE_CW = $clog2(CHUNK);
    localparam int IDX_W   = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    localparam logic [CNT_W-1:0] ACC_STEP = CNT_W'(CHUNK);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } state_t;

    state_t             state;
    logic [DATA_W-1:0]  shift_reg;
    logic [CNT_W-1:0]   acc;
    logic [IDX_W-1:0]   idx;

    logic [CHUNK-1:0]   slice;
    logic [CORE_CW-1:0] core_count;
    logic               core_valid;
    logic [CNT_W-1:0]   acc_next;

    // The operand is shifted left as zero slices are consumed, so the slice
    // under inspection is always the top CHUNK bits.
    assign slice = shift_reg[DATA_W-1 -: CHUNK];

    lzc_core #(
        .WIDTH(CHUNK)
    ) u_lzc (
        .data  (slice),
        .count (core_count),
        .valid (core_valid)
    );

    assign acc_next = acc + {{(CNT_W - CORE_CW){1'b0}}, core_count};
    assign in_ready = (state == ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            shift_reg <= '0;
            acc       <= '0;
            idx       <= '0;
            out_valid <= 1'b0;
            out_count <= '0;
            out_zero  <= 1'b0;
`ifdef LZC_SEQ_NORM_EN
            out_norm  <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        shift_reg <= in_data;
                        acc       <= '0;
                        idx       <= '0;
                        state     <= ST_SCAN;
                    end
                end

                ST_SCAN: begin
                    if (core_valid) begin
                        out_count <= acc_next;
                        out_zero  <= 1'b0;
`ifdef LZC_SEQ_NORM_EN
                        // shift_reg is already aligned to the slice boundary;
                        // only the in-slice offset remains.
                        out_norm  <= shift_reg << core_count;
`endif
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end else if (idx == LAST_IDX) begin
                        out_count <= FULL_CNT;
                        out_zero  <= 1'b1;
`ifdef LZC_SEQ_NORM_EN
                        out_norm  <= '0;
`endif
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        acc       <= acc + ACC_STEP;
                        shift_reg <= shift_reg << CHUNK;
                        idx       <= idx + IDX_W'(1);
                    end
                end

                ST_DONE: begin
                    // Result fields stay as-is after the handshake; only
                    // out_valid drops.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    out_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lzc_seq_scanner.sv
// tb/tb_lzc_seq_scanner.sv - self-checking bench for lzc_seq_scanner (CHUNK=16, CHUNKS=4)
module tb_lzc_seq_scanner;
    localparam int CHUNK  = 16;
    localparam int CHUNKS = 4;
    localparam int DATA_W = 64;
    localparam int CNT_W  = 7;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  out_count;
    logic              out_zero;
`ifdef LZC_SEQ_NORM_EN
    logic [DATA_W-1:0] out_norm;
`endif

    always #5 clk = ~clk;

    lzc_seq_scanner #(
        .CHUNK  (CHUNK),
        .CHUNKS (CHUNKS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .out_zero  (out_zero)
`ifdef LZC_SEQ_NORM_EN
        ,
        .out_norm  (out_norm)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Leading zeros by direct bit search over the whole operand.
    function automatic int lz(input logic [63:0] d);
        for (int i = 63; i >= 0; i--)
            if (d[i]) return 63 - i;
        return 64;
    endfunction

    // Timeline model: an accepted operand whose first set bit lies in slice k
    // produces a result visible after edge (accept_edge + k + 1); an all-zero
    // operand behaves like k = CHUNKS-1.
    bit          armed = 1'b0;
    bit          m_busy = 1'b0;
    int          m_edge = 0;
    int          m_vfrom = 0;
    logic [6:0]  m_count, p_count;
    logic        m_zero, p_zero;
    logic [63:0] m_norm, p_norm;

    always @(posedge clk) begin
        int n;
        int k;
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_count <= '0;
            m_zero  <= 1'b0;
            m_norm  <= '0;
            armed   <= 1'b1;
        end else if (m_busy && m_edge >= m_vfrom && out_ready) begin
            m_busy <= 1'b0;
        end else if (m_busy && m_edge + 1 == m_vfrom) begin
            m_count <= p_count;
            m_zero  <= p_zero;
            m_norm  <= p_norm;
        end else if (!m_busy && in_valid) begin
            n = lz(in_data);
            k = (n >= DATA_W) ? CHUNKS - 1 : n / CHUNK;
            m_busy  <= 1'b1;
            p_count <= 7'(n);
            p_zero  <= (n == DATA_W);
            p_norm  <= (n >= DATA_W) ? 64'h0 : (in_data << n);
            m_vfrom <= m_edge + k + 2;
        end
        m_edge <= m_edge + 1;
    end

    always @(negedge clk) begin
        if (armed && rst_n) begin
            check("mdl_in_ready", 64'(in_ready), 64'(!m_busy));
            check("mdl_out_valid", 64'(out_valid), 64'(m_busy && m_edge >= m_vfrom));
            check("mdl_out_count", 64'(out_count), 64'(m_count));
            check("mdl_out_zero", 64'(out_zero), 64'(m_zero));
`ifdef LZC_SEQ_NORM_EN
            check("mdl_out_norm", out_norm, m_norm);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int c = 0;
        while (!in_ready && c < 20) begin
            tick();
            c++;
        end
        check("wait_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic wait_valid(output int c);
        c = 1;
        while (!out_valid && c < 20) begin
            tick();
            c++;
        end
    endtask

    // Sends one operand; stall = number of valid cycles with out_ready low;
    // junk keeps in_valid high with other data while the block is busy.
    task automatic run_op(input string tag, input logic [63:0] d, input int stall,
                          input logic [6:0] exp_cnt, input logic exp_z,
                          input logic [63:0] exp_norm, input int exp_cyc, input bit junk);
        int c;
        wait_ready();
        in_valid  = 1'b1;
        in_data   = d;
        out_ready = (stall == 0);
        tick();
        in_valid = junk;
        in_data  = ~d;
        wait_valid(c);
        check({tag, "_latency"}, 64'(c), 64'(exp_cyc));
        check({tag, "_count"}, 64'(out_count), 64'(exp_cnt));
        check({tag, "_zero"}, 64'(out_zero), 64'(exp_z));
`ifdef LZC_SEQ_NORM_EN
        check({tag, "_norm"}, out_norm, exp_norm);
`else
        if (exp_norm == 64'hDEAD) $display("unused");
`endif
        for (int s = 0; s < stall; s++) begin
            tick();
            check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, "_hold_count"}, 64'(out_count), 64'(exp_cnt));
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, "_post_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_post_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_post_count"}, 64'(out_count), 64'(exp_cnt));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;

        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_count", 64'(out_count), 64'd0);
        check("rst_out_zero", 64'(out_zero), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Pin the reference counter against hand-computed values.
        check("lz_msb", 64'(lz(64'h8000_0000_0000_0000)), 64'd0);
        check("lz_bit16", 64'(lz(64'h0000_0000_0001_0000)), 64'd47);
        check("lz_ff", 64'(lz(64'h0000_00FF_0000_0000)), 64'd24);
        check("lz_zero", 64'(lz(64'h0)), 64'd64);

        run_op("msb", 64'h8000_0000_0000_0000, 0, 7'd0, 1'b0, 64'h8000_0000_0000_0000, 2, 1'b0);
        run_op("bit16", 64'h0000_0000_0001_0000, 0, 7'd47, 1'b0, 64'h8000_0000_0000_0000, 4, 1'b0);
        run_op("allzero", 64'h0, 0, 7'd64, 1'b1, 64'h0, 5, 1'b0);
        run_op("stall", 64'h0000_00FF_0000_0000, 3, 7'd24, 1'b0, 64'hFF00_0000_0000_0000, 3, 1'b1);

        // Back-to-back with in_valid held high.
        wait_ready();
        in_valid  = 1'b1;
        in_data   = 64'h1;
        out_ready = 1'b1;
        tick();
        in_data = 64'h4000_0000_0000_0000;
        wait_valid(c);
        check("b2b_first_latency", 64'(c), 64'd5);
        check("b2b_first_count", 64'(out_count), 64'd63);
        tick();
        check("b2b_bubble_ready", 64'(in_ready), 64'd1);
        check("b2b_bubble_valid", 64'(out_valid), 64'd0);
        tick();
        in_valid = 1'b0;
        wait_valid(c);
        check("b2b_second_latency", 64'(c), 64'd2);
        check("b2b_second_count", 64'(out_count), 64'd1);
        tick();

        // Reset in the middle of scanning an all-zero operand.
        wait_ready();
        in_valid = 1'b1;
        in_data  = 64'h0;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_count", 64'(out_count), 64'd0);
        check("mid_rst_zero", 64'(out_zero), 64'd0);
        check("mid_rst_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("mid_rst_no_valid", 64'(out_valid), 64'd0);
        end
        run_op("after_rst", 64'h1, 0, 7'd63, 1'b0, 64'h8000_0000_0000_0000, 5, 1'b0);

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
